// File: rtl/vector_acc_pkg.sv
// vector_acc_pkg
//   Shared definitions for the vector accumulator slice:
//   - DT_SIGNED / DT_UNSIGNED : accepted DATA_TYPE strings
//   - calc_addr_width()       : channel index width for a given depth
//   - sat_max() / sat_min()   : saturation limits for a width and signedness,
//                               returned right-aligned in 64 bits (the caller
//                               truncates to its own width)
package vector_acc_pkg;

  localparam string DT_SIGNED   = "signed";
  localparam string DT_UNSIGNED = "unsigned";

  // A depth of 1 still needs a one-bit index so ports never collapse to zero width.
  function automatic int calc_addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic logic [63:0] sat_max(input int width, input bit is_signed);
    logic [63:0] one;
    one = 64'd1;
    if (is_signed)       return (one << (width - 1)) - one;
    else if (width >= 64) return '1;
    else                 return (one << width) - one;
  endfunction

  // Signed minimum is the two's complement of the signed maximum minus one,
  // i.e. 1000...0 once truncated to width.
  function automatic logic [63:0] sat_min(input int width, input bit is_signed);
    logic [63:0] one;
    one = 64'd1;
    if (is_signed) return ~((one << (width - 1)) - one);
    else           return '0;
  endfunction

endpackage

// File: rtl/acc_ram_sdp.sv
// acc_ram_sdp
//   Simple dual-port RAM: one synchronous write port, one read port with a
//   single registered read stage. Written so synthesis infers block or
//   distributed RAM. Contents are not initialised or reset.
// Ports:
//   clk    : clock, rising edge
//   we     : write enable
//   waddr  : write address
//   wdata  : write data
//   raddr  : read address, sampled every cycle
//   rdata  : mem[raddr] from the previous cycle
module acc_ram_sdp
  import vector_acc_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int WIDTH = 32,
  parameter int AW    = calc_addr_width(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/vector_accumulator.sv
// vector_accumulator
//   Element-wise accumulation of a streamed vector of VECTOR_LEN samples over
//   many frames. Partial sums live in acc_ram_sdp and are updated by a
//   three-stage read-modify-write pipeline:
//     S0 : register sample, channel index, frame flag, first-frame marker
//     S1 : RAM read (registered read data lines up with the S1 registers)
//     S2 : add / restart, write back, register the finished sum to dout
//   A sample accepted in cycle n is written back and (if due) reported at n+3.
//
//   Handshake: din_valid is a one-way strobe with no ready. Every cycle with
//   din_valid=1 is one accepted sample for the current channel; dout_valid is
//   likewise a one-cycle strobe the consumer must take unconditionally.
//
//   Optional build macro VECTOR_ACC_SATURATE_EN: saturating add in S2 and a
//   sticky ovf_flag output. Without it the add wraps and ovf_flag is absent.
//
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   din        : sample for the current channel
//   din_valid  : sample strobe, advances the channel counter
//   new_acc    : with din_valid on channel 0, starts a new accumulation
//   dout       : finished sum for dout_addr
//   dout_addr  : channel index of dout
//   dout_valid : one beat per channel when a finished sum is reported
//   sync_err   : sticky, new_acc seen on a channel other than 0
//   ovf_flag   : (saturating build only) sticky, some add saturated
module vector_accumulator
  import vector_acc_pkg::*;
#(
  parameter int    DIN_WIDTH  = 16,
  parameter int    ACC_WIDTH  = 32,
  parameter int    VECTOR_LEN = 64,
  parameter string DATA_TYPE  = "signed",
  parameter int    ADDR_WIDTH = calc_addr_width(VECTOR_LEN)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DIN_WIDTH-1:0]  din,
  input  logic                  din_valid,
  input  logic                  new_acc,
  output logic [ACC_WIDTH-1:0]  dout,
  output logic [ADDR_WIDTH-1:0] dout_addr,
  output logic                  dout_valid,
  output logic                  sync_err
`ifdef VECTOR_ACC_SATURATE_EN
  ,
  output logic                  ovf_flag
`endif
);

  localparam bit IS_SIGNED = (DATA_TYPE == DT_SIGNED);
  localparam logic [ADDR_WIDTH-1:0] LAST_CH = ADDR_WIDTH'(VECTOR_LEN - 1);

  // The write of channel c lands before any later read of c because at least
  // four beats separate successive visits of the same channel.
  if (VECTOR_LEN < 4) begin : g_len_chk
    $error("vector_accumulator: VECTOR_LEN must be >= 4");
  end
  if (ACC_WIDTH < DIN_WIDTH) begin : g_width_chk
    $error("vector_accumulator: ACC_WIDTH must be >= DIN_WIDTH");
  end
  if (DATA_TYPE != DT_SIGNED && DATA_TYPE != DT_UNSIGNED) begin : g_type_chk
    $error("vector_accumulator: DATA_TYPE must be \"signed\" or \"unsigned\"");
  end

  // Input side
  logic [ADDR_WIDTH-1:0] cnt;
  logic                  frame_flag;
  logic                  first_acc;
  logic                  cur_flag;

  // Pipeline registers
  logic                  s0_valid, s1_valid;
  logic [DIN_WIDTH-1:0]  s0_din, s1_din;
  logic [ADDR_WIDTH-1:0] s0_addr, s1_addr;
  logic                  s0_flag, s1_flag;
  logic                  s0_first, s1_first;

  // Datapath
  logic [ACC_WIDTH-1:0]  rd_data;
  logic [ACC_WIDTH-1:0]  din_ext;
  logic [ACC_WIDTH-1:0]  add_res;
  logic [ACC_WIDTH-1:0]  wr_data;
  logic                  restart;
  logic                  out_fire;
  logic                  ram_we;

  // Channel 0 takes new_acc directly; later channels reuse what channel 0 latched.
  assign cur_flag = (cnt == '0) ? new_acc : frame_flag;

  assign restart  = s1_flag || s1_first;
  assign out_fire = s1_valid && s1_flag && !s1_first;
  // A write still in S2 when reset hits is dropped.
  assign ram_we   = s1_valid && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      frame_flag <= 1'b0;
      first_acc  <= 1'b1;
      sync_err   <= 1'b0;
      s0_valid   <= 1'b0;
      s1_valid   <= 1'b0;
      dout       <= '0;
      dout_addr  <= '0;
      dout_valid <= 1'b0;
    end else begin
      if (din_valid) begin
        cnt <= (cnt == LAST_CH) ? '0 : cnt + 1'b1;
        if (cnt == '0)   frame_flag <= new_acc;
        else if (new_acc) sync_err  <= 1'b1;
        if (cnt == LAST_CH) first_acc <= 1'b0;
      end
      s0_valid   <= din_valid;
      s1_valid   <= s0_valid;
      dout_valid <= out_fire;
      if (out_fire) begin
        dout      <= rd_data;
        dout_addr <= s1_addr;
      end
    end
  end

  // Payload registers need no reset; their valids gate every use.
  always_ff @(posedge clk) begin
    s0_din   <= din;
    s0_addr  <= cnt;
    s0_flag  <= cur_flag;
    s0_first <= first_acc;
    s1_din   <= s0_din;
    s1_addr  <= s0_addr;
    s1_flag  <= s0_flag;
    s1_first <= s0_first;
  end

  acc_ram_sdp #(
    .DEPTH (VECTOR_LEN),
    .WIDTH (ACC_WIDTH),
    .AW    (ADDR_WIDTH)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (s1_addr),
    .wdata (wr_data),
    .raddr (s0_addr),
    .rdata (rd_data)
  );

  always_comb begin
    din_ext = ACC_WIDTH'(s1_din);
    if (IS_SIGNED) din_ext = ACC_WIDTH'({{ACC_WIDTH{s1_din[DIN_WIDTH-1]}}, s1_din});
  end

`ifdef VECTOR_ACC_SATURATE_EN
  localparam logic [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'(sat_max(ACC_WIDTH, IS_SIGNED));
  localparam logic [ACC_WIDTH-1:0] SAT_MIN = ACC_WIDTH'(sat_min(ACC_WIDTH, IS_SIGNED));

  logic [ACC_WIDTH:0] sum_wide;
  logic               sat_hit;

  // One guard bit: signed overflow shows as guard != msb, unsigned as carry.
  always_comb begin
    sum_wide = {(IS_SIGNED ? rd_data[ACC_WIDTH-1] : 1'b0), rd_data}
             + {(IS_SIGNED ? din_ext[ACC_WIDTH-1] : 1'b0), din_ext};
    sat_hit  = IS_SIGNED ? (sum_wide[ACC_WIDTH] != sum_wide[ACC_WIDTH-1])
                         : sum_wide[ACC_WIDTH];
    add_res  = sum_wide[ACC_WIDTH-1:0];
    if (sat_hit) add_res = (IS_SIGNED && sum_wide[ACC_WIDTH]) ? SAT_MIN : SAT_MAX;
  end

  always_ff @(posedge clk) begin
    if (rst)                                   ovf_flag <= 1'b0;
    else if (s1_valid && !restart && sat_hit)  ovf_flag <= 1'b1;
  end
`else
  always_comb begin
    add_res = rd_data + din_ext;
  end
`endif

  assign wr_data = restart ? din_ext : add_res;

endmodule

// File: tb/tb_vector_accumulator.sv
// tb_vector_accumulator
//   Directed bench for vector_accumulator. Instance A: VECTOR_LEN=4, signed,
//   16/32 bits. Instance B: VECTOR_LEN=4, unsigned, 8/10 bits. Inputs are
//   driven 1 time unit after a rising edge, outputs sampled at the same point,
//   so the output seen after call k belongs to the beat driven in call k-3.
//   Honours VECTOR_ACC_SATURATE_EN for the ovf_flag port and the B wrap value.
module tb_vector_accumulator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  // Instance A
  logic        a_rst = 1'b1;
  logic [15:0] a_din = '0;
  logic        a_v   = 1'b0;
  logic        a_new = 1'b0;
  logic [31:0] a_dout;
  logic [1:0]  a_addr;
  logic        a_dv;
  logic        a_serr;
  // Instance B
  logic        b_rst = 1'b1;
  logic [7:0]  b_din = '0;
  logic        b_v   = 1'b0;
  logic        b_new = 1'b0;
  logic [9:0]  b_dout;
  logic [1:0]  b_addr;
  logic        b_dv;
  logic        b_serr;
`ifdef VECTOR_ACC_SATURATE_EN
  logic        a_ovf;
  logic        b_ovf;
`endif

  vector_accumulator #(
    .DIN_WIDTH(16), .ACC_WIDTH(32), .VECTOR_LEN(4), .DATA_TYPE("signed")
  ) dut_a (
    .clk(clk), .rst(a_rst), .din(a_din), .din_valid(a_v), .new_acc(a_new),
    .dout(a_dout), .dout_addr(a_addr), .dout_valid(a_dv), .sync_err(a_serr)
`ifdef VECTOR_ACC_SATURATE_EN
    , .ovf_flag(a_ovf)
`endif
  );

  vector_accumulator #(
    .DIN_WIDTH(8), .ACC_WIDTH(10), .VECTOR_LEN(4), .DATA_TYPE("unsigned")
  ) dut_b (
    .clk(clk), .rst(b_rst), .din(b_din), .din_valid(b_v), .new_acc(b_new),
    .dout(b_dout), .dout_addr(b_addr), .dout_valid(b_dv), .sync_err(b_serr)
`ifdef VECTOR_ACC_SATURATE_EN
    , .ovf_flag(b_ovf)
`endif
  );

  // ---------------- drivers ----------------
  task automatic cyc_a(input logic v, input logic [15:0] d, input logic n);
    @(posedge clk); #1;
    a_v = v; a_din = d; a_new = n;
  endtask

  task automatic cyc_b(input logic v, input logic [7:0] d, input logic n);
    @(posedge clk); #1;
    b_v = v; b_din = d; b_new = n;
  endtask

  task automatic do_reset_a();
    @(posedge clk); #1;
    a_rst = 1'b1; a_v = 1'b0; a_new = 1'b0; a_din = '0;
    @(posedge clk); #1;
    a_rst = 1'b0;
  endtask

  task automatic do_reset_b();
    @(posedge clk); #1;
    b_rst = 1'b1; b_v = 1'b0; b_new = 1'b0; b_din = '0;
    @(posedge clk); #1;
    b_rst = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset_a();
    do_reset_b();
    chk_cnt++; if (a_dout !== 32'd0) $display("FAIL reset_a_dout got %0h want 0", a_dout); else pass_cnt++;
    chk_cnt++; if (a_addr !== 2'd0) $display("FAIL reset_a_addr got %0d want 0", a_addr); else pass_cnt++;
    chk_cnt++; if (a_dv !== 1'b0) $display("FAIL reset_a_dv got %0b want 0", a_dv); else pass_cnt++;
    chk_cnt++; if (a_serr !== 1'b0) $display("FAIL reset_a_serr got %0b want 0", a_serr); else pass_cnt++;
    chk_cnt++; if (b_dout !== 10'd0) $display("FAIL reset_b_dout got %0h want 0", b_dout); else pass_cnt++;
    chk_cnt++; if (b_dv !== 1'b0) $display("FAIL reset_b_dv got %0b want 0", b_dv); else pass_cnt++;
`ifdef VECTOR_ACC_SATURATE_EN
    chk_cnt++; if (a_ovf !== 1'b0) $display("FAIL reset_a_ovf got %0b want 0", a_ovf); else pass_cnt++;
    chk_cnt++; if (b_ovf !== 1'b0) $display("FAIL reset_b_ovf got %0b want 0", b_ovf); else pass_cnt++;
`endif
  endtask

  // Frames of 1,2,3,4 with new_acc on frames 0 and 3: frame 3 reports 3,6,9,12.
  task automatic test_frames_signed();
    int s;
    logic ev;
    logic [31:0] ed;
    do_reset_a();
    for (int k = 0; k < 19; k++) begin
      if (k < 16) cyc_a(1'b1, 16'(k % 4 + 1), (k == 0 || k == 12));
      else        cyc_a(1'b0, 16'd0, 1'b0);
      s  = k - 3;
      ev = (s >= 12 && s < 16);
      ed = ev ? 32'(3 * (s % 4 + 1)) : 32'd0;
      chk_cnt++; if (a_dv !== ev) $display("FAIL frames_dv k=%0d got %0b want %0b", k, a_dv, ev); else pass_cnt++;
      if (ev) begin
        chk_cnt++; if (a_dout !== ed) $display("FAIL frames_dout k=%0d got %0d want %0d", k, a_dout, ed); else pass_cnt++;
        chk_cnt++; if (a_addr !== 2'(s % 4)) $display("FAIL frames_addr k=%0d got %0d want %0d", k, a_addr, s % 4); else pass_cnt++;
      end
    end
  endtask

  // Continues from the previous test (RAM holds 1..4). Alternate valid beats:
  // frame accumulates to 2,4,6,8, next frame reports them with the same gaps.
  task automatic test_gaps();
    int s, b;
    logic v, ev;
    logic [31:0] ed;
    for (int k = 0; k < 19; k++) begin
      v = (k % 2 == 0) && (k < 16);
      b = k / 2;
      cyc_a(v, 16'(b % 4 + 1), v && (b == 4));
      s  = k - 3;
      ev = (s >= 0) && (s < 16) && (s % 2 == 0) && (s / 2 >= 4);
      ed = ev ? 32'(2 * ((s / 2) % 4 + 1)) : 32'd0;
      chk_cnt++; if (a_dv !== ev) $display("FAIL gaps_dv k=%0d got %0b want %0b", k, a_dv, ev); else pass_cnt++;
      if (ev) begin
        chk_cnt++; if (a_dout !== ed) $display("FAIL gaps_dout k=%0d got %0d want %0d", k, a_dout, ed); else pass_cnt++;
        chk_cnt++; if (a_addr !== 2'((s / 2) % 4)) $display("FAIL gaps_addr k=%0d got %0d want %0d", k, a_addr, (s / 2) % 4); else pass_cnt++;
      end
    end
  endtask

  // -32768 on every channel for two frames -> -65536 = 0xFFFF0000.
  task automatic test_signed_min();
    int s;
    logic ev;
    do_reset_a();
    for (int k = 0; k < 15; k++) begin
      if (k < 12) cyc_a(1'b1, 16'h8000, (k == 0 || k == 8));
      else        cyc_a(1'b0, 16'd0, 1'b0);
      s  = k - 3;
      ev = (s >= 8 && s < 12);
      chk_cnt++; if (a_dv !== ev) $display("FAIL min_dv k=%0d got %0b want %0b", k, a_dv, ev); else pass_cnt++;
      if (ev) begin
        chk_cnt++; if (a_dout !== 32'hFFFF0000) $display("FAIL min_dout k=%0d got %0h want ffff0000", k, a_dout); else pass_cnt++;
      end
    end
`ifdef VECTOR_ACC_SATURATE_EN
    chk_cnt++; if (a_ovf !== 1'b0) $display("FAIL min_ovf got %0b want 0", a_ovf); else pass_cnt++;
`endif
  endtask

  // new_acc on channel 2 is ignored (sum keeps growing to 10) and sets a
  // sticky sync_err; a mid-frame reset clears it and restarts at channel 0.
  task automatic test_sync_and_reset();
    int s;
    logic ev;
    do_reset_a();
    for (int k = 0; k < 15; k++) begin
      if (k < 12) cyc_a(1'b1, 16'd5, (k == 0 || k == 6 || k == 8));
      else        cyc_a(1'b0, 16'd0, 1'b0);
      s  = k - 3;
      ev = (s >= 8 && s < 12);
      chk_cnt++; if (a_serr !== (k >= 7)) $display("FAIL sync_err k=%0d got %0b want %0b", k, a_serr, (k >= 7)); else pass_cnt++;
      chk_cnt++; if (a_dv !== ev) $display("FAIL sync_dv k=%0d got %0b want %0b", k, a_dv, ev); else pass_cnt++;
      if (ev) begin
        chk_cnt++; if (a_dout !== 32'd10) $display("FAIL sync_dout k=%0d got %0d want 10", k, a_dout); else pass_cnt++;
        chk_cnt++; if (a_addr !== 2'(s % 4)) $display("FAIL sync_addr k=%0d got %0d want %0d", k, a_addr, s % 4); else pass_cnt++;
      end
    end
    // Two beats of a frame, then reset while they are in flight.
    cyc_a(1'b1, 16'd9, 1'b1);
    cyc_a(1'b1, 16'd9, 1'b0);
    do_reset_a();
    chk_cnt++; if (a_serr !== 1'b0) $display("FAIL rst_serr got %0b want 0", a_serr); else pass_cnt++;
    for (int k = 0; k < 11; k++) begin
      if (k < 4)      cyc_a(1'b1, 16'd7, 1'b0);
      else if (k < 8) cyc_a(1'b1, 16'd1, (k == 4));
      else            cyc_a(1'b0, 16'd0, 1'b0);
      s  = k - 3;
      ev = (s >= 4 && s < 8);
      chk_cnt++; if (a_dv !== ev) $display("FAIL rst_dv k=%0d got %0b want %0b", k, a_dv, ev); else pass_cnt++;
      if (ev) begin
        chk_cnt++; if (a_dout !== 32'd7) $display("FAIL rst_dout k=%0d got %0d want 7", k, a_dout); else pass_cnt++;
        chk_cnt++; if (a_addr !== 2'(s % 4)) $display("FAIL rst_addr k=%0d got %0d want %0d", k, a_addr, s % 4); else pass_cnt++;
      end
    end
  endtask

  // Unsigned 8/10: four frames of 255 -> 1020; five frames -> 1275 wraps to
  // 251, or clamps to 1023 with ovf_flag in the saturating build.
  task automatic test_unsigned_wrap();
    int s;
    logic ev;
    logic [9:0] ed;
`ifdef VECTOR_ACC_SATURATE_EN
    logic [9:0] late = 10'd1023;
`else
    logic [9:0] late = 10'd251;
`endif
    do_reset_b();
    for (int k = 0; k < 43; k++) begin
      if (k < 40) cyc_b(1'b1, 8'd255, (k == 0 || k == 16 || k == 36));
      else        cyc_b(1'b0, 8'd0, 1'b0);
      s  = k - 3;
      ev = (s >= 16 && s < 20) || (s >= 36 && s < 40);
      ed = (s < 30) ? 10'd1020 : late;
      chk_cnt++; if (b_dv !== ev) $display("FAIL uns_dv k=%0d got %0b want %0b", k, b_dv, ev); else pass_cnt++;
      if (ev) begin
        chk_cnt++; if (b_dout !== ed) $display("FAIL uns_dout k=%0d got %0d want %0d", k, b_dout, ed); else pass_cnt++;
        chk_cnt++; if (b_addr !== 2'(s % 4)) $display("FAIL uns_addr k=%0d got %0d want %0d", k, b_addr, s % 4); else pass_cnt++;
      end
`ifdef VECTOR_ACC_SATURATE_EN
      if (k == 30) begin
        chk_cnt++; if (b_ovf !== 1'b0) $display("FAIL uns_ovf_early got %0b want 0", b_ovf); else pass_cnt++;
      end
`endif
    end
`ifdef VECTOR_ACC_SATURATE_EN
    chk_cnt++; if (b_ovf !== 1'b1) $display("FAIL uns_ovf got %0b want 1", b_ovf); else pass_cnt++;
`endif
    chk_cnt++; if (b_serr !== 1'b0) $display("FAIL uns_serr got %0b want 0", b_serr); else pass_cnt++;
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_frames_signed();
    test_gaps();
    test_signed_min();
    test_sync_and_reset();
    test_unsigned_wrap();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached after %0d/%0d checks", pass_cnt, chk_cnt);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/vector_accumulator.md
Name: vector_accumulator

Overview:
- Multi-channel successor of the scalar accumulator: accumulates a streamed vector of VECTOR_LEN samples (e.g. FFT bins, one per valid beat) element-wise over many frames.
- Partial sums live in an internal RAM of depth VECTOR_LEN, updated by a read-modify-write pipeline.
- When a new accumulation starts, each finished sum is streamed out with its channel index.
- Sits after FFT/power stages, ahead of packetisers or readout BRAMs.

Parameters:
- DIN_WIDTH, 16, input sample width.
- ACC_WIDTH, 32, accumulator and output width; must be >= DIN_WIDTH.
- VECTOR_LEN, 64, channels per frame; must be >= 4, any integer.
- DATA_TYPE, "signed", "signed" or "unsigned" arithmetic.
- ADDR_WIDTH, $clog2(VECTOR_LEN), channel index width (derived, do not override).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- din  in  DIN_WIDTH  sample for the current channel.
- din_valid  in  1  din is valid; channel counter advances once per valid beat.
- new_acc  in  1  qualified by din_valid on channel 0; marks the first frame of a new accumulation.
- dout  out  ACC_WIDTH  completed sum for channel dout_addr.
- dout_addr  out  ADDR_WIDTH  channel index of dout.
- dout_valid  out  1  dout/dout_addr valid, one beat per channel.
- sync_err  out  1  sticky; new_acc seen with din_valid on a channel other than 0.

Behaviour:
- Reset (synchronous, active-high): channel counter=0, pipeline valids=0, dout=0, dout_addr=0, dout_valid=0, sync_err=0, first_acc flag=1. RAM contents are not cleared.
- Channel counter: increments on each din_valid; wraps VECTOR_LEN-1 -> 0. Gaps in din_valid are allowed anywhere; the counter holds during gaps.
- Frame start flag: new_acc is latched when din_valid=1 and counter=0, and applies to the whole frame (channels 0..VECTOR_LEN-1). On other channels new_acc is ignored and sets sync_err. sync_err clears only on rst.
- Pipeline: S0 registers din/valid/flag/addr; S1 does the RAM read (1-cycle latency); S2 adds and writes back. Fixed latency 3: sample accepted at cycle n -> write-back and dout_valid at n+3.
- Update rule, per channel c:
  - if the frame flag is set or first_acc=1: RAM[c] <= sign/zero-extended din.
  - else: RAM[c] <= RAM[c] + din. Wrap-around on overflow in the base build.
- Output:
  - When the flag is set and first_acc=0, dout <= old RAM[c] (the finished sum) and dout_addr <= c, with dout_valid high for 1 cycle at n+3.
  - Output beats follow the input valid pattern, including its gaps.
  - No output is produced during the first frame after reset.
- first_acc: clears at the end of the first complete frame after reset, when channel VECTOR_LEN-1 is accepted.
- Hazard: the read for channel c+1 or c+2 cannot collide with the write to c because VECTOR_LEN >= 4. No forwarding is needed; this is guaranteed by the parameter check (elaboration error if VECTOR_LEN < 4).
- Signed mode: add operands are sign-extended. Unsigned mode: operands are zero-extended.
- Reset mid-frame: the pipeline is flushed, the in-flight write is discarded, and the next valid beat is channel 0 of a fresh first frame.
- No backpressure: the consumer must accept dout_valid every cycle it is asserted.

Optional Feature:
- Macro VECTOR_ACC_SATURATE_EN.
- Defined: the S2 adder saturates to the ACC_WIDTH min/max for the data type. It is signed or unsigned per DATA_TYPE; the unsigned minimum is never reached.
  - Adds an output ovf_flag (1 bit, sticky, cleared by rst), set when any add saturates.
- Undefined: plain modular add, and no ovf_flag port.

Decomposition:
- Shared package vector_acc_pkg holds:
  - ADDR_WIDTH computation function.
  - DATA_TYPE string constants.
  - Saturation min/max constant functions.
- One sub-module: acc_ram_sdp, a simple-dual-port RAM with 1-cycle registered read and depth/width parameters, synthesis-inferable as BRAM/LUTRAM.
- Counter, flag and adder logic stay in the top.

Test Plan:
- VECTOR_LEN=4, signed. Frames of din=1,2,3,4 with new_acc on frames 0 and 3 -> at frame 3, dout=3,6,9,12 for dout_addr=0..3, each exactly 3 cycles after the corresponding input. No dout during frame 0.
- Unsigned, DIN=8/ACC=10. Four frames of din=255 then new_acc -> dout=1020. Fifth accumulated frame wraps: 1275 mod 1024 = 251. With VECTOR_LEN_ACC_SATURATE... correction: with VECTOR_ACC_SATURATE_EN, dout=1023 and ovf_flag=1.
- Signed, din=-32768 on all channels for 2 frames then new_acc -> dout=-65536 (0xFFFF0000 on 32 bits).
- din_valid toggling 1-0-1-0 through a frame -> same sums as the contiguous case; dout_valid pulses mirror the input gaps.
- new_acc asserted on channel 2 -> ignored for accumulation and sync_err=1 until rst. Then rst asserted mid-frame -> next valid beat is treated as channel 0 and no dout appears for one frame.
